ins_dec_pipe: RTL and testbench

Registered, parametrised RV32I instruction decode stage covering all six base formats (R/I/S/B/U/J), not just U-type. It takes raw 32-bit instruction words plus PC from fetch over a valid/ready handshake. It emits decoded fields, a format tag, an illegal flag and a fully formed XLEN-wide sign-extended immediate toward issue. It sits between the fetch buffer and register-read, and provides a 2-entry skid buffer so backpressure never drops or duplicates an instruction.

---
 rtl/ins_dec_pkg.sv | 56 +++++
 rtl/ins_dec_rv32i_comb.sv | 97 +++++++++
 rtl/ins_dec_pipe.sv | 130 +++++++++++++
 tb/tb_ins_dec_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ins_dec_pkg
// Brief    : Shared types and constants for the RV32I decode stage.
// Revision : 1.0
// ============================================================================
package ins_dec_pkg;

    // Widest supported datapath; narrower XLEN uses the low bits.
    localparam int XLEN_MAX = 64;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0]          op;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        logic [2:0]          fmt;
        logic                illegal;
        logic [XLEN_MAX-1:0] pc;
    } dec_word_t;

    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ins_dec_rv32i_comb.sv
`default_nettype none
// ============================================================================
// Module   : ins_dec_rv32i_comb
// Brief    : Combinational RV32I word decoder producing a packed decoded word.
// Revision : 1.0
// ============================================================================
module ins_dec_rv32i_comb
    import ins_dec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ZERO_UNUSED = 1'b1
) (
    input  logic [31:0]     i_ins,
    input  logic [XLEN-1:0] i_pc,
    output dec_word_t       o_dec
);

    logic [2:0]  w_fmt;
    logic [31:0] w_imm32;
    logic        w_shift_imm;

    always_comb begin
        w_fmt = FMT_ILL;
        case (i_ins[6:0])
            OPC_LUI, OPC_AUIPC:                 w_fmt = FMT_U;
            OPC_JAL:                            w_fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:           w_fmt = FMT_I;
            OPC_STORE:                          w_fmt = FMT_S;
            OPC_BRANCH:                         w_fmt = FMT_B;
            OPC_OP:                             w_fmt = FMT_R;
            default:                            w_fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{i_ins[31]}}, i_ins[31:20]};
            FMT_S: w_imm32 = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
            FMT_B: w_imm32 = {{19{i_ins[31]}}, i_ins[31], i_ins[7],
                              i_ins[30:25], i_ins[11:8], 1'b0};
            FMT_U: w_imm32 = {i_ins[31:12], 12'd0};
            FMT_J: w_imm32 = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12],
                              i_ins[20], i_ins[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Shift-immediates carry funct7 (arithmetic vs logical) in ins[31:25].
    assign w_shift_imm = (i_ins[6:0] == OPC_OP_IMM) &&
                         ((i_ins[14:12] == 3'b001) || (i_ins[14:12] == 3'b101));

    always_comb begin
        o_dec         = '0;
        o_dec.op      = i_ins[6:0];
        o_dec.funct3  = i_ins[14:12];
        o_dec.funct7  = i_ins[31:25];
        o_dec.rs1     = i_ins[19:15];
        o_dec.rs2     = i_ins[24:20];
        o_dec.rd      = i_ins[11:7];
        o_dec.imm     = sext32(w_imm32);
        o_dec.fmt     = w_fmt;
        o_dec.illegal = (w_fmt == FMT_ILL);
        o_dec.pc      = XLEN_MAX'(i_pc);
        if (ZERO_UNUSED) begin
            case (w_fmt)
                FMT_U, FMT_J: begin
                    o_dec.funct3 = 3'd0;
                    o_dec.funct7 = 7'd0;
                    o_dec.rs1    = 5'd0;
                    o_dec.rs2    = 5'd0;
                end
                FMT_S, FMT_B: begin
                    o_dec.rd     = 5'd0;
                    o_dec.funct7 = 7'd0;
                end
                FMT_I: begin
                    o_dec.rs2 = 5'd0;
                    if (!w_shift_imm) begin
                        o_dec.funct7 = 7'd0;
                    end
                end
                FMT_ILL: begin
                    o_dec.funct3 = 3'd0;
                    o_dec.funct7 = 7'd0;
                    o_dec.rs1    = 5'd0;
                    o_dec.rs2    = 5'd0;
                    o_dec.rd     = 5'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ins_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ins_dec_pipe
// Brief    : Registered RV32I decode stage with a 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
module ins_dec_pipe
    import ins_dec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ZERO_UNUSED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_op,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    dec_word_t w_dec;
    dec_word_t r_main_q, w_main_d;
    dec_word_t r_skid_q, w_skid_d;
    state_t    r_state_q, w_state_d;
    logic      r_in_ready_q, w_in_ready_d;
    logic      r_out_valid_q, w_out_valid_d;
    logic      w_in_fire;
    logic      w_out_fire;

    ins_dec_rv32i_comb #(
        .XLEN        (XLEN),
        .ZERO_UNUSED (ZERO_UNUSED)
    ) u_dec (
        .i_ins (in_ins),
        .i_pc  (in_pc),
        .o_dec (w_dec)
    );

    assign w_in_fire  = in_valid & r_in_ready_q;
    assign w_out_fire = r_out_valid_q & out_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_main_d  = r_main_q;
        w_skid_d  = r_skid_q;
        case (r_state_q)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_d  = w_dec;
                    w_state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_d = w_dec;
                end else if (w_out_fire) begin
                    w_state_d = ST_EMPTY;
                end else if (w_in_fire) begin
                    w_skid_d  = w_dec;
                    w_state_d = ST_TWO;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_main_d  = r_skid_q;
                    w_state_d = ST_ONE;
                end
            end
            default: w_state_d = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_d = ST_EMPTY;
        end
        // Handshake flags follow next state so both leave the stage registered.
        w_in_ready_d  = (w_state_d != ST_TWO);
        w_out_valid_d = (w_state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_EMPTY;
            r_main_q      <= '0;
            r_skid_q      <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_main_q      <= w_main_d;
            r_skid_q      <= w_skid_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow_xlen
            logic w_unused_hi;
            assign w_unused_hi = ^{r_main_q.imm[XLEN_MAX-1:XLEN],
                                   r_main_q.pc[XLEN_MAX-1:XLEN]};
        end
    endgenerate

    assign in_ready    = r_in_ready_q;
    assign out_valid   = r_out_valid_q;
    assign out_op      = r_main_q.op;
    assign out_funct3  = r_main_q.funct3;
    assign out_funct7  = r_main_q.funct7;
    assign out_rs1     = r_main_q.rs1;
    assign out_rs2     = r_main_q.rs2;
    assign out_rd      = r_main_q.rd;
    assign out_imm     = r_main_q.imm[XLEN-1:0];
    assign out_fmt     = r_main_q.fmt;
    assign out_illegal = r_main_q.illegal;
    assign out_pc      = r_main_q.pc[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ins_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_dec_pipe
// Brief    : Scoreboard bench for the RV32I decode pipe (XLEN=32).
// Revision : 1.0
// ============================================================================
module tb_ins_dec_pipe;
    import ins_dec_pkg::*;

    localparam int XLEN  = 32;
    localparam int N_TBL = 12;

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
        logic [XLEN-1:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_ins = 32'd0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [6:0]      out_op;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    exp_t        sb[$];
    exp_t        drv_exp = '0;
    logic [31:0] tbl_w[N_TBL];
    exp_t        tbl_e[N_TBL];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;

    ins_dec_pipe #(.XLEN(XLEN), .ZERO_UNUSED(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [2:0] fmt,
                                input logic ill, input logic [31:0] pc);
        mk = {op, f3, f7, rs1, rs2, rd, imm, fmt, ill, pc};
    endfunction

    // Fire decisions are made at the negedge, where inputs and DUT state are stable.
    always @(negedge clk) begin : mon
        exp_t act;
        exp_t e;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                act = {out_op, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
                       out_imm, out_fmt, out_illegal, out_pc};
                n_tests++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: unexpected output op=%h pc=%h, required no output",
                             out_op, out_pc);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL sb_word: got op=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h fmt=%0d ill=%b pc=%h, required op=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h fmt=%0d ill=%b pc=%h",
                                 act.op, act.f3, act.f7, act.rs1, act.rs2, act.rd, act.imm, act.fmt, act.ill, act.pc,
                                 e.op, e.f3, e.f7, e.rs1, e.rs2, e.rd, e.imm, e.fmt, e.ill, e.pc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(drv_exp);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_word(input int idx);
        in_valid = 1'b1;
        in_ins   = tbl_w[idx];
        in_pc    = tbl_e[idx].pc;
        drv_exp  = tbl_e[idx];
    endtask

    task automatic load_table;
        tbl_w[0]  = 32'h123450B7; tbl_e[0]  = mk(7'h37, 3'd0, 7'h00, 5'd0,  5'd0, 5'd1, 32'h12345000, FMT_U,   1'b0, 32'h100);
        tbl_w[1]  = 32'hFE000EE3; tbl_e[1]  = mk(7'h63, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, FMT_B,   1'b0, 32'h104);
        tbl_w[2]  = 32'h4020D093; tbl_e[2]  = mk(7'h13, 3'd5, 7'h20, 5'd1,  5'd0, 5'd1, 32'h00000402, FMT_I,   1'b0, 32'h108);
        tbl_w[3]  = 32'h0000007F; tbl_e[3]  = mk(7'h7F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00000000, FMT_ILL, 1'b1, 32'h10C);
        tbl_w[4]  = 32'h00000000; tbl_e[4]  = mk(7'h00, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00000000, FMT_ILL, 1'b1, 32'h110);
        tbl_w[5]  = 32'h00112623; tbl_e[5]  = mk(7'h23, 3'd2, 7'h00, 5'd2,  5'd1, 5'd0, 32'h0000000C, FMT_S,   1'b0, 32'h114);
        tbl_w[6]  = 32'h0080006F; tbl_e[6]  = mk(7'h6F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00000008, FMT_J,   1'b0, 32'h118);
        tbl_w[7]  = 32'h00208133; tbl_e[7]  = mk(7'h33, 3'd0, 7'h00, 5'd1,  5'd2, 5'd2, 32'h00000000, FMT_R,   1'b0, 32'h11C);
        tbl_w[8]  = 32'hFFF00093; tbl_e[8]  = mk(7'h13, 3'd0, 7'h00, 5'd0,  5'd0, 5'd1, 32'hFFFFFFFF, FMT_I,   1'b0, 32'h120);
        tbl_w[9]  = 32'hFFFFF117; tbl_e[9]  = mk(7'h17, 3'd0, 7'h00, 5'd0,  5'd0, 5'd2, 32'hFFFFF000, FMT_U,   1'b0, 32'h124);
        tbl_w[10] = 32'hFF852283; tbl_e[10] = mk(7'h03, 3'd2, 7'h00, 5'd10, 5'd0, 5'd5, 32'hFFFFFFF8, FMT_I,   1'b0, 32'h128);
        tbl_w[11] = 32'h00000031; tbl_e[11] = mk(7'h31, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0, 32'h00000000, FMT_ILL, 1'b1, 32'h12C);
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_handshake: got valid/ready=%b, required 01", {out_valid, in_ready});
        end
        n_tests++;
        if ({out_op, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
             out_imm, out_fmt, out_illegal, out_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got op=%h imm=%h fmt=%0d ill=%b pc=%h, required all 0",
                     out_op, out_imm, out_fmt, out_illegal, out_pc);
        end
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got valid/ready=%b, required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < N_TBL; i++) begin
            step();
            drive_word(i);
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready: word %0d got %b, required 1", i, in_ready);
            end
            if (i > 0) begin
                n_tests++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_out_valid: word %0d got %b, required 1", i, out_valid);
                end
            end
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_last_latency: got %b, required 1", out_valid);
        end
        step();
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got valid=%b pending=%0d, required valid=0 pending=0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_backpressure;
        logic [99:0] snap;
        int          k;
        int          n0;
        k    = 0;
        n0   = n_out;
        snap = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            out_ready = (cyc >= 3);
            if (k < 4) drive_word(k + 4);
            else in_valid = 1'b0;
            @(negedge clk);
            if (cyc == 1) begin
                snap = {out_op, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
                        out_imm, out_fmt, out_illegal, out_pc};
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_ready_before: got %b, required 1", in_ready);
                end
            end
            if (cyc == 2) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready_drop: got %b, required 0", in_ready);
                end
                n_tests++;
                if ({out_valid, out_op, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
                     out_imm, out_fmt, out_illegal, out_pc} !== {1'b1, snap}) begin
                    n_fail++;
                    $display("FAIL bp_stable: got valid=%b op=%h imm=%h pc=%h, required valid=1 op=%h imm=%h pc=%h",
                             out_valid, out_op, out_imm, out_pc, snap[99:93], snap[67:36], snap[31:0]);
                end
            end
            if (in_valid && in_ready) k++;
        end
        #1;
        n_tests++;
        if (k != 4 || (n_out - n0) != 4 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got accepted=%0d emitted=%0d pending=%0d, required 4 4 0",
                     k, n_out - n0, sb.size());
        end
    endtask

    task automatic test_flush;
        int n0;
        out_ready = 1'b0;
        step(); drive_word(0);
        step(); drive_word(1);
        step(); drive_word(2); flush = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_two: got valid/ready=%b, required 01", {out_valid, in_ready});
        end
        out_ready = 1'b0;
        step(); drive_word(3);
        step(); drive_word(5); flush = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n0 = n_out;
        for (int c = 0; c < 4; c++) step();
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || n_out != n0) begin
            n_fail++;
            $display("FAIL flush_one_drop: got valid=%b emitted=%0d, required valid=0 emitted=0",
                     out_valid, n_out - n0);
        end
    endtask

    task automatic test_async_reset;
        int n0;
        out_ready = 1'b0;
        step(); drive_word(7);
        step(); drive_word(8);
        step(); in_valid = 1'b0;
        #1 rst = 1'b1; flush = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL arst_handshake: got valid/ready=%b, required 01", {out_valid, in_ready});
        end
        n_tests++;
        if ({out_op, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
             out_imm, out_fmt, out_illegal, out_pc} !== '0) begin
            n_fail++;
            $display("FAIL arst_fields: got op=%h rd=%0d imm=%h pc=%h, required all 0",
                     out_op, out_rd, out_imm, out_pc);
        end
        step();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        n0 = n_out;
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || n_out != n0) begin
            n_fail++;
            $display("FAIL arst_no_replay: got valid=%b emitted=%0d, required valid=0 emitted=0",
                     out_valid, n_out - n0);
        end
    endtask

    initial begin
        load_table();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
